// File: rtl/matrix_vector_assembler_pkg.sv
// Shared definitions for the matrix/vector assembler: FSM encoding and
// constant helpers for matrix geometry.
package matrix_vector_assembler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int max_dim(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Bit offset of element (r,c) inside a row-major packed matrix.
    function automatic int elem_off(input int r, input int c, input int m, input int nbits);
        return ((r * m) + c) * nbits;
    endfunction

endpackage

// File: rtl/matrix_vector_assembler_if.sv
// Handshake and data bus of the matrix/vector assembler; master drives
// the pass controls and vectors, slave is the assembler itself.
interface matrix_vector_assembler_if
    import matrix_vector_assembler_pkg::*;
#(
    parameter int nBits = 32,
    parameter int N     = 4,
    parameter int M     = 4,
    parameter int IW    = 2
);
    localparam int VL = max_dim(N, M);

    logic                     start;
    logic                     col_mode;
    logic                     use_idx;
    logic [0:nBits*N*M-1]     mat_in;
    logic [0:nBits*VL-1]      vec_in;
    logic [IW-1:0]            vec_idx;
    logic                     vec_valid;
    logic                     vec_ready;
    logic [0:nBits*N*M-1]     mat_out;
    logic                     busy;
    logic                     done;
    logic                     err;

    modport master (
        output start, col_mode, use_idx, mat_in, vec_in, vec_idx, vec_valid,
        input  vec_ready, mat_out, busy, done, err
    );

    modport slave (
        input  start, col_mode, use_idx, mat_in, vec_in, vec_idx, vec_valid,
        output vec_ready, mat_out, busy, done, err
    );

endinterface

// File: rtl/matrix_vector_assembler.sv
// Loads a base N x M matrix, then overwrites whole rows or columns one
// vector per handshake; flags done after Total accepts.
module matrix_vector_assembler
    import matrix_vector_assembler_pkg::*;
#(
    parameter int nBits = 32,
    parameter int N     = 4,
    parameter int M     = 4,
    parameter int IW    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    matrix_vector_assembler_if.slave  bus
);

    localparam int            MW         = nBits * N * M;
    localparam logic [IW:0]   ROWS_TOTAL = (IW+1)'(N);
    localparam logic [IW:0]   COLS_TOTAL = (IW+1)'(M);

    state_e           r_state;
    logic [IW:0]      r_count;
    logic             r_col_mode;
    logic             r_use_idx;
    logic [0:MW-1]    r_mat_out;
    logic             r_done;
    logic             r_err;
    logic             r_vec_ready;
    logic             r_busy;

    logic             w_accept;
    logic [IW:0]      w_target;
    logic [IW:0]      w_total;
    logic [IW:0]      w_count_inc;
    logic             w_in_range;
    logic             w_wr;
    logic [0:MW-1]    w_mat_next;

    assign w_accept    = bus.vec_valid & r_vec_ready;
    assign w_target    = r_use_idx ? {1'b0, bus.vec_idx} : r_count;
    assign w_total     = r_col_mode ? COLS_TOTAL : ROWS_TOTAL;
    assign w_count_inc = r_count + (IW+1)'(1);
    assign w_in_range  = (w_target < w_total);
    assign w_wr        = w_accept & w_in_range;

    // Per-element next value: a hit selects the vector element lying along the written line.
    for (genvar r = 0; r < N; r++) begin : g_row
        for (genvar c = 0; c < M; c++) begin : g_col
            localparam int OFF = elem_off(r, c, M, nBits);
            logic w_hit;
            assign w_hit = r_col_mode ? (w_target == (IW+1)'(c))
                                      : (w_target == (IW+1)'(r));
            assign w_mat_next[OFF +: nBits] =
                (w_wr & w_hit) ? (r_col_mode ? bus.vec_in[r*nBits +: nBits]
                                             : bus.vec_in[c*nBits +: nBits])
                               : r_mat_out[OFF +: nBits];
        end
    end

    // Pass-control FSM with registered status outputs; start wins over any pending vector.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_count     <= '0;
            r_col_mode  <= 1'b0;
            r_use_idx   <= 1'b0;
            r_mat_out   <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_vec_ready <= 1'b0;
            r_busy      <= 1'b0;
        end else if (bus.start) begin
            r_state     <= ST_FILL;
            r_count     <= '0;
            r_col_mode  <= bus.col_mode;
            r_use_idx   <= bus.use_idx;
            r_mat_out   <= bus.mat_in;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_vec_ready <= 1'b1;
            r_busy      <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_IDLE;
                end
                ST_FILL: begin
                    if (w_accept) begin
                        r_mat_out <= w_mat_next;
                        r_count   <= w_count_inc;
                        if (!w_in_range) begin
                            r_err <= 1'b1;
                        end else begin
                            r_err <= r_err;
                        end
                        if (w_count_inc == w_total) begin
                            r_state     <= ST_DONE;
                            r_done      <= 1'b1;
                            r_vec_ready <= 1'b0;
                            r_busy      <= 1'b0;
                        end else begin
                            r_state <= ST_FILL;
                        end
                    end else begin
                        r_state <= ST_FILL;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_DONE;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_count     <= '0;
                    r_done      <= 1'b0;
                    r_vec_ready <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mat_out   = r_mat_out;
    assign bus.done      = r_done;
    assign bus.err       = r_err;
    assign bus.vec_ready = r_vec_ready;
    assign bus.busy      = r_busy;

endmodule

// File: tb/tb_matrix_vector_assembler.sv
// Directed scoreboard bench for the matrix/vector assembler (8-bit, 3x4).
module tb_matrix_vector_assembler;

    localparam int NB = 8;
    localparam int N  = 3;
    localparam int M  = 4;
    localparam int IW = 2;
    localparam int MW = NB * N * M;
    localparam int VW = NB * 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    matrix_vector_assembler_if #(.nBits(NB), .N(N), .M(M), .IW(IW)) bus();

    matrix_vector_assembler #(.nBits(NB), .N(N), .M(M), .IW(IW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0]    em [N][M];
    bit            m_col, m_use, m_err, m_done, m_busy;
    int            m_cnt;
    logic [0:MW-1] sbq [$];

    function automatic logic [0:MW-1] pack_model();
        logic [0:MW-1] p;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < M; c++)
                p[(r*M+c)*NB +: NB] = em[r][c];
        return p;
    endfunction

    task automatic chk(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_mat"},   bus.mat_out,   pack_model());
        chk({tag, "_done"},  bus.done,      m_done);
        chk({tag, "_err"},   bus.err,       m_err);
        chk({tag, "_busy"},  bus.busy,      m_busy);
        chk({tag, "_ready"}, bus.vec_ready, m_busy);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_mat"},   bus.mat_out,   '0);
        chk({tag, "_done"},  bus.done,      1'b0);
        chk({tag, "_err"},   bus.err,       1'b0);
        chk({tag, "_busy"},  bus.busy,      1'b0);
        chk({tag, "_ready"}, bus.vec_ready, 1'b0);
        m_done = 1'b0; m_err = 1'b0; m_busy = 1'b0; m_cnt = 0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < M; c++)
                em[r][c] = 8'h00;
    endtask

    task automatic do_start(input logic [7:0] fill, input bit col, input bit uidx, input bit with_valid);
        bus.mat_in    = {(N*M){fill}};
        bus.col_mode  = col;
        bus.use_idx   = uidx;
        bus.start     = 1'b1;
        bus.vec_valid = with_valid;
        tick();
        bus.start     = 1'b0;
        bus.vec_valid = 1'b0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < M; c++)
                em[r][c] = fill;
        m_col = col; m_use = uidx; m_cnt = 0;
        m_err = 1'b0; m_done = 1'b0; m_busy = 1'b1;
    endtask

    task automatic send(input logic [0:VW-1] v, input logic [IW-1:0] idx, input string tag);
        int wait_cyc;
        int tgt;
        int tot;
        wait_cyc      = 0;
        bus.vec_in    = v;
        bus.vec_idx   = idx;
        bus.vec_valid = 1'b1;
        while (!bus.vec_ready && wait_cyc < 20) begin
            tick();
            wait_cyc++;
        end
        chk({tag, "_rdy_wait"}, bus.vec_ready, 1'b1);
        if (!bus.vec_ready) begin
            bus.vec_valid = 1'b0;
            return;
        end
        tot = m_col ? M : N;
        tgt = m_use ? int'(idx) : m_cnt;
        if (tgt < tot) begin
            if (m_col) begin
                for (int k = 0; k < N; k++) em[k][tgt] = v[k*NB +: NB];
            end else begin
                for (int k = 0; k < M; k++) em[tgt][k] = v[k*NB +: NB];
            end
        end else begin
            m_err = 1'b1;
        end
        m_cnt++;
        if (m_cnt == tot) begin
            m_done = 1'b1;
            m_busy = 1'b0;
        end
        sbq.push_back(pack_model());
        tick();
        bus.vec_valid = 1'b0;
        chk({tag, "_mat"},   bus.mat_out,   sbq.pop_front());
        chk({tag, "_done"},  bus.done,      m_done);
        chk({tag, "_err"},   bus.err,       m_err);
        chk({tag, "_ready"}, bus.vec_ready, m_busy);
    endtask

    initial begin
        bus.start = 1'b0; bus.col_mode = 1'b0; bus.use_idx = 1'b0;
        bus.mat_in = '0; bus.vec_in = '0; bus.vec_idx = '0; bus.vec_valid = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        chk_reset("reset");
        rst = 1'b0;

        // Row auto-increment, back-to-back
        do_start(8'h11, 1'b0, 1'b0, 1'b0);
        chk_state("t1_start");
        send(32'h01020304, 2'd0, "t1_r0");
        send(32'h05060708, 2'd0, "t1_r1");
        send(32'h090A0B0C, 2'd0, "t1_r2");
        chk("t1_final", bus.mat_out, 96'h0102030405060708090A0B0C);
        tick();
        chk_state("t1_hold");

        // Column indexed, restart from DONE
        do_start(8'h00, 1'b1, 1'b1, 1'b0);
        chk_state("t2_start");
        send(32'hA3B3C300, 2'd3, "t2_c3");
        send(32'hA0B0C000, 2'd0, "t2_c0");
        send(32'hA2B2C200, 2'd2, "t2_c2");
        send(32'hA1B1C100, 2'd1, "t2_c1");
        chk("t2_final", bus.mat_out, 96'hA0A1A2A3B0B1B2B3C0C1C2C3);

        // Out-of-range index
        do_start(8'h33, 1'b0, 1'b1, 1'b0);
        send(32'hDEADBEEF, 2'd3, "t3_oor");
        chk("t3_oor_mat", bus.mat_out, {12{8'h33}});
        send(32'h10111213, 2'd0, "t3_r0");
        send(32'h20212223, 2'd2, "t3_r2");
        chk("t3_final", bus.mat_out, 96'h10111213333333332021222_3);

        // Abort: start together with the 2nd row
        do_start(8'h44, 1'b0, 1'b0, 1'b0);
        send(32'h01010101, 2'd0, "t4_r0");
        bus.vec_in = 32'h02020202;
        do_start(8'h55, 1'b0, 1'b0, 1'b1);
        chk_state("t4_abort");
        send(32'h0A0B0C0D, 2'd0, "t4_n0");
        send(32'h1A1B1C1D, 2'd0, "t4_n1");
        send(32'h2A2B2C2D, 2'd0, "t4_n2");

        // Backpressure gaps, ignored vectors in DONE and IDLE
        do_start(8'h66, 1'b0, 1'b0, 1'b0);
        send(32'hC0C1C2C3, 2'd0, "t5_r0");
        repeat (3) tick();
        chk_state("t5_gap1");
        send(32'hD0D1D2D3, 2'd0, "t5_r1");
        repeat (2) tick();
        send(32'hE0E1E2E3, 2'd0, "t5_r2");
        bus.vec_in = 32'hFFFFFFFF; bus.vec_valid = 1'b1;
        tick();
        tick();
        chk_state("t5_done_ign");
        bus.vec_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset("t5_rst_done");
        bus.vec_valid = 1'b1;
        tick();
        tick();
        chk_reset("t5_idle_ign");
        bus.vec_valid = 1'b0;
        do_start(8'h77, 1'b0, 1'b0, 1'b0);
        send(32'h12345678, 2'd0, "t5_mid");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset("t5_midrst");

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/matrix_vector_assembler.md
Name: matrix_vector_assembler

Overview:
- Sequential successor to the single-row matrix builder: loads a base N x M matrix, then overwrites whole rows or whole columns one vector per handshake.
- Two addressing options: auto-increment or explicit index.
- Asserts done once all N rows (or all M columns) have been written.
- Sits between the vector-producing stages (e.g. per-row division/normalisation) and the pseudo-inverse output register.

Parameters:
- nBits, 32, element width in bits.
- N, 4, matrix rows.
- M, 4, matrix columns.
- IW, 2, index width; must satisfy 2**IW >= max(N,M).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- start  input  1  pulse; loads mat_in and begins a fill pass.
- col_mode  input  1  sampled at start: 0 = write rows (M elements), 1 = write columns (N elements).
- use_idx  input  1  sampled at start: 0 = auto-increment target, 1 = target from vec_idx.
- mat_in  input  [0:nBits*N*M-1]  base matrix, row-major; element (r,c) at [(r*M+c)*nBits +: nBits].
- vec_in  input  [0:nBits*max(N,M)-1]  vector; element k at [k*nBits +: nBits]; only the first M (row mode) or N (column mode) elements are used.
- vec_idx  input  IW  target row/column when use_idx=1.
- vec_valid  input  1  vector present.
- vec_ready  output  1  high only in FILL.
- mat_out  output reg  [0:nBits*N*M-1]  assembled matrix, same layout as mat_in.
- busy  output  1  high in FILL.
- done  output reg  1  high in DONE; held until the next start or rst.
- err  output reg  1  sticky flag: an indexed vector was out of range; cleared by start or rst.

Behaviour:
- Reset: mat_out=0, done=0, err=0, state IDLE, count=0, busy=0, vec_ready=0.
- States IDLE, FILL, DONE. Total = N in row mode, M in column mode.
- IDLE:
  - start -> FILL.
  - On that edge: mat_out<=mat_in; col_mode and use_idx latched; count<=0; err<=0; done<=0.
- FILL:
  - Accept occurs on vec_valid & vec_ready.
  - Target = count (auto mode) or vec_idx (indexed mode).
  - Row mode: elements (target, 0..M-1) <= vec_in elements 0..M-1.
  - Column mode: elements (0..N-1, target) <= vec_in elements 0..N-1.
  - All other elements hold their value.
  - count increments on every accept.
  - Indexed target >= Total: vector is accepted but discarded, err<=1, count still increments.
  - The accept that makes count == Total moves the block to DONE on the same edge; done=1 the next cycle.
- DONE:
  - mat_out frozen; vec_ready=0.
  - start restarts exactly as from IDLE.
- Latency:
  - A written vector is visible on mat_out one cycle after its accept edge.
  - done rises one cycle after the final accept edge, coincident with the final write becoming visible.
- Simultaneous start and vec_valid in FILL: start wins; the vector is not written and the pass restarts from mat_in. This aborts the pass in progress.
- vec_valid while in IDLE or DONE: ignored, since vec_ready=0.
- Indexed mode may hit the same target repeatedly; the last write wins, and done still fires after Total accepts.
- rst mid-pass: returns to the reset values on the next edge; no partial hold.
- count width is IW+1; it never wraps, because FILL exits at Total.
- vec_ready is combinational from state only: no dependence on vec_valid, no combinational path from inputs.

Decomposition:
- Shared package holds:
  - state encoding IDLE/FILL/DONE;
  - max(N,M) constant function;
  - element-offset function (r,c) -> (r*M+c)*nBits.
- Single module. The row/column write is a generate loop over elements with per-element enables; no sub-module is warranted.

Test Plan (nBits=8, N=3, M=4, IW=2):
- Reset, then rst held 2 cycles -> mat_out=0, done=0, busy=0, vec_ready=0, err=0.
- Row auto: mat_in all 0x11; start; send rows {01,02,03,04}, {05..08}, {09..0C} back-to-back -> mat_out = 01..0C row-major; done=1 exactly 1 cycle after the 3rd accept; vec_ready=0 after.
- Column indexed: mat_in all 0; col_mode=1, use_idx=1; write cols 3,0,2,1, each as {A0+c,B0+c,C0+c} -> element (r,c) = {A,B,C}[r]0+c; done after the 4th accept; err=0.
- Out-of-range: row indexed, vec_idx=3 with N=3 -> err=1, mat_out unchanged, count advances; two further valid rows give done=1 with err still 1.
- Abort: start asserted with vec_valid during the 2nd row of a pass -> 2nd row not written; mat_out = new mat_in; count=0; 3 fresh rows are needed for done.
- Backpressure and idle: vec_valid toggled with gaps; vec_valid in DONE and IDLE ignored -> mat_out unchanged; rst in mid-FILL -> all outputs return to reset values the next cycle.
